// File: rtl/soc_mem_copy_pkg.sv
// Shared definitions for the word-at-a-time memory copy master.
package soc_mem_copy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_FIN     = 3'd4
  } copy_state_e;

  localparam int          WORD_BYTES  = 4;
  localparam logic [3:0]  BYTE_EN_ALL = 4'b1111;

endpackage

// File: rtl/soc_mem_copy_master.sv
// Avalon-MM master copying a block of 32-bit words, one read then one write per word,
// while accumulating a modulo-2^32 checksum of the data read.
module soc_mem_copy_master
  import soc_mem_copy_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [31:0]       checksum,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic [31:0]       m_writedata,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  input  logic              m_waitrequest
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(WORD_BYTES);

  copy_state_e       state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  words_done_q, words_done_d;
  logic [31:0]       checksum_q, checksum_d;
  logic [31:0]       buf_q, buf_d;
  logic              aborted_q, aborted_d;
  logic              abort_pend_q, abort_pend_d;
  logic              fin_wait_q, fin_wait_d;
  logic [LEN_W-1:0]  words_inc;
  logic              last_word;

  assign words_inc = words_done_q + LEN_W'(1);
  assign last_word = (words_inc == len_q);

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    words_done_d = words_done_q;
    checksum_d   = checksum_q;
    buf_d        = buf_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    fin_wait_d   = fin_wait_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d        = src_addr & ALIGN_MASK;
          dst_d        = dst_addr & ALIGN_MASK;
          len_d        = len;
          words_done_d = '0;
          checksum_d   = '0;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
          // A zero-length copy spends one busy cycle in FIN before pulsing done.
          fin_wait_d   = (len == '0);
          state_d      = (len == '0) ? ST_FIN : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (abort) abort_pend_d = 1'b1;
        if (!m_waitrequest) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (abort) abort_pend_d = 1'b1;
        if (m_readdatavalid) begin
          buf_d      = m_readdata;
          checksum_d = checksum_q + m_readdata;
          state_d    = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (abort) abort_pend_d = 1'b1;
        if (!m_waitrequest) begin
          words_done_d = words_inc;
          src_d        = src_q + ADDR_STEP;
          dst_d        = dst_q + ADDR_STEP;
          if (last_word || abort || abort_pend_q) begin
            aborted_d = !last_word;
            state_d   = ST_FIN;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_FIN: begin
        if (fin_wait_q) fin_wait_d = 1'b0;
        else            state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      words_done_q <= '0;
      checksum_q   <= '0;
      buf_q        <= '0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      fin_wait_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      words_done_q <= words_done_d;
      checksum_q   <= checksum_d;
      buf_q        <= buf_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      fin_wait_q   <= fin_wait_d;
    end
  end

  // Strobes decode straight from the state register so reset removes them at once.
  assign m_read       = (state_q == ST_RD_REQ);
  assign m_write      = (state_q == ST_WR_REQ);
  assign m_address    = (state_q == ST_WR_REQ) ? dst_q : src_q;
  assign m_writedata  = buf_q;
  assign m_byteenable = (m_read || m_write) ? BYTE_EN_ALL : 4'b0000;

  assign busy       = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT) ||
                      (state_q == ST_WR_REQ) || ((state_q == ST_FIN) && fin_wait_q);
  assign done       = (state_q == ST_FIN) && !fin_wait_q;
  assign aborted    = aborted_q;
  assign checksum   = checksum_q;
  assign words_done = words_done_q;

endmodule

// File: doc/soc_mem_copy_master.md
# soc_mem_copy_master

Avalon-MM master that copies a block of 32-bit words from one region of the on-chip data memory to another, one word at a time, and reports a running checksum of the data moved. It is the initiator for the single-port 8192x32 data memory slave. It sits on the SoC interconnect beside the Nios II data master and is started by a one-cycle pulse from a control register block.

## Interface
- `ADDR_W`, 15: byte-address width on the master port; word-aligned, covers 8192 words.
- `LEN_W`, 14: width of the word count; maximum value is 8192.
- `clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; latches `src_addr`, `dst_addr` and `len`.
- `abort` in 1: level request to stop early; sampled every cycle while busy.
- `src_addr` in ADDR_W: source byte address; bits [1:0] are ignored and treated as 0.
- `dst_addr` in ADDR_W: destination byte address; bits [1:0] are ignored.
- `len` in LEN_W: number of 32-bit words to copy.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the transfer ends.
- `aborted` out 1: valid with `done`; held until the next `start`.
- `checksum` out 32: modulo-2^32 sum of all words read in this transfer; held until the next `start`.
- `words_done` out LEN_W: count of words written; held until the next `start`.
- `m_address` out ADDR_W: master byte address, always word-aligned.
- `m_read` out 1, `m_write` out 1: Avalon read and write strobes.
- `m_byteenable` out 4: constant 4'b1111 while a strobe is asserted.
- `m_writedata` out 32: data for the write.
- `m_readdata` in 32, `m_readdatavalid` in 1, `m_waitrequest` in 1: standard Avalon-MM master inputs.

## Operation
- FSM states and transitions:
  - IDLE: on `start` with `len`=0, go to FIN. On `start` with `len`>0, go to RD_REQ.
  - RD_REQ: assert `m_read` with `m_address`=src; leave when `m_waitrequest`=0.
  - RD_WAIT: wait for `m_readdatavalid`, then capture the word into a one-word buffer, add it to `checksum`, and go to WR_REQ.
  - WR_REQ: assert `m_write` with `m_address`=dst and the buffered data; leave when `m_waitrequest`=0.
  - On leaving WR_REQ: increment `words_done` and advance src and dst by 4.
    - Go to FIN if `words_done`+1 = `len` or `abort` is high.
    - Otherwise go back to RD_REQ.
  - FIN: pulse `done` for 1 cycle, then return to IDLE.
- At most one read is outstanding. `m_read` and `m_write` are never high together.
- Strobes and address are held stable while `m_waitrequest`=1. A transaction is never withdrawn.
- `abort` never cuts a bus transaction short.
  - Abort seen in RD_REQ or RD_WAIT: the read and its paired write still complete, then the block goes to FIN with `aborted`=1.
  - `aborted`=1 only when the block stopped before `words_done`=`len`.
- `start` while busy is ignored. `start` and `abort` arriving together in IDLE: the start is taken, and the abort is seen in the next state.
- Address arithmetic is modulo 2^ADDR_W, so addresses wrap from 0x7FFC to 0x0000.
- Overlapping regions are copied in ascending order. When dst > src the overlap is replicated forward; this is defined behaviour.
- Reset values: IDLE; `busy`, `done`, `aborted`, `m_read`, `m_write` = 0; `checksum`, `words_done`, `m_address`, `m_writedata` = 0.
- Reset in the middle of a transfer forces IDLE immediately. Any in-flight `m_readdatavalid` arriving after reset is ignored in IDLE.

## Timing
- Best case with zero wait states and read latency 1: 3 cycles per word (RD_REQ, RD_WAIT, WR_REQ).
- Total for N words with no waits: `start` at cycle 0, `busy` high at cycle 1, `done` at cycle 3N+1.
- `len`=0: `done` at cycle 2 with `words_done`=0 and `checksum`=0.
- Each wait-state cycle adds exactly 1 cycle. Each extra cycle of read latency adds 1 cycle in RD_WAIT.
- `busy` falls in the same cycle that `done` is high.

## Structure
- Shared package `soc_mem_copy_pkg` holds:
  - the state enum (IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN);
  - `WORD_BYTES`=4;
  - the byteenable constant 4'b1111.
- Single module with no sub-module. The checksum adder and the counters are inline.

## Test plan
- Copy 4 words, src 0x0000 to dst 0x1000, source words 1,2,3,4, zero wait states -> dst holds 1,2,3,4; `checksum`=0xA; `words_done`=4; `done` at cycle 13; `aborted`=0.
- `len`=0 -> no `m_read` or `m_write`; `done` at cycle 2; `checksum`=0.
- Copy 3 words with `m_waitrequest` high for 2 cycles on every read and every write -> address and strobes stable while waiting; `done` at cycle 3*3+12+1=22.
- Copy 2 words from src 0x7FFC to dst 0x0100 -> second read at 0x0000; dst holds mem[0x7FFC], mem[0x0000].
- Copy 10 words with `abort` raised during RD_WAIT of word 3 -> word 3 is written; `done` with `words_done`=3 and `aborted`=1.
- `reset` asserted while in WR_REQ of word 2 -> `m_write` drops asynchronously; all outputs at reset values; a later `readdatavalid` pulse leaves the state in IDLE.
